// File: rtl/wb_queue_if.sv
// Writeback queue bus: producer handshakes, register-file write side,
// operand lookup/forward and occupancy status.
interface wb_queue_if #(
   parameter int unsigned XLEN  = 64,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 5
);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   // ALU result path
   logic                   alu_valid;
   logic                   alu_ready;
   logic [AW-1:0]          alu_rd;
   logic [XLEN-1:0]        alu_data;

   // Load result path
   logic                   mem_valid;
   logic                   mem_ready;
   logic [AW-1:0]          mem_rd;
   logic [XLEN-1:0]        mem_data;

   // Register-file write port
   logic                   rf_grant;
   logic                   Wen;
   logic [AW-1:0]          Rd_addr;
   logic signed [XLEN-1:0] write_data;

   // Operand bypass lookup
   logic [AW-1:0]          Rs1_addr;
   logic [AW-1:0]          Rs2_addr;
   logic                   rs1_hit;
   logic [XLEN-1:0]        rs1_fwd;
   logic                   rs2_hit;
   logic [XLEN-1:0]        rs2_fwd;

   // Occupancy
   logic [CW-1:0]          count;
   logic                   empty;

   // Queue side
   modport slave (
      input  alu_valid, alu_rd, alu_data,
      input  mem_valid, mem_rd, mem_data,
      input  rf_grant,
      input  Rs1_addr, Rs2_addr,
      output alu_ready, mem_ready,
      output Wen, Rd_addr, write_data,
      output rs1_hit, rs1_fwd, rs2_hit, rs2_fwd,
      output count, empty
   );

   // Producer / register-file side
   modport master (
      output alu_valid, alu_rd, alu_data,
      output mem_valid, mem_rd, mem_data,
      output rf_grant,
      output Rs1_addr, Rs2_addr,
      input  alu_ready, mem_ready,
      input  Wen, Rd_addr, write_data,
      input  rs1_hit, rs1_fwd, rs2_hit, rs2_fwd,
      input  count, empty
   );
endinterface

// File: rtl/wb_queue.sv
// In-order writeback queue feeding the register-file write port, with a
// youngest-match bypass lookup for two source operands.
module wb_queue #(
   parameter int unsigned XLEN  = 64,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 5
) (
   input logic      clk,
   input logic      rst,
   wb_queue_if.slave bus
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   // Storage and pointers
   logic [AW-1:0]   rd_q   [DEPTH];
   logic [XLEN-1:0] data_q [DEPTH];
   logic [PW-1:0]   head_q, head_d;
   logic [PW-1:0]   tail_q, tail_d;
   logic [CW-1:0]   count_q, count_d;

   // Output stage
   logic            wen_q, wen_d;
   logic [AW-1:0]   rd_addr_q, rd_addr_d;
   logic [XLEN-1:0] wdata_q, wdata_d;

   // Handshake / control
   logic            mem_ready_c;
   logic            alu_ready_c;
   logic            take_mem_c;
   logic            take_alu_c;
   logic [AW-1:0]   in_rd_c;
   logic [XLEN-1:0] in_data_c;
   logic            push_c;
   logic            pop_c;

   // Lookup
   logic [AW-1:0]   rs_addr_c [2];
   logic            hit_c     [2];
   logic [XLEN-1:0] fwd_c     [2];

   // Acceptance: load path has fixed priority; readiness ignores same-cycle pop
   always_comb begin
      mem_ready_c = !rst && (count_q < CW'(DEPTH));
      alu_ready_c = mem_ready_c && !bus.mem_valid;
      take_mem_c  = bus.mem_valid && mem_ready_c;
      take_alu_c  = bus.alu_valid && alu_ready_c;
      in_rd_c     = take_mem_c ? bus.mem_rd   : bus.alu_rd;
      in_data_c   = take_mem_c ? bus.mem_data : bus.alu_data;
      // Writes to x0 complete the handshake but are never queued
      push_c      = (take_mem_c || take_alu_c) && (in_rd_c != '0);
      pop_c       = bus.rf_grant && (count_q != '0);
   end

   // Next-state for pointers, occupancy and the output stage
   always_comb begin
      head_d    = head_q;
      tail_d    = tail_q;
      count_d   = count_q;
      wen_d     = 1'b0;
      rd_addr_d = rd_addr_q;
      wdata_d   = wdata_q;

      if (push_c) begin
         tail_d = tail_q + PW'(1);
      end
      if (pop_c) begin
         head_d    = head_q + PW'(1);
         wen_d     = 1'b1;
         rd_addr_d = rd_q[head_q];
         wdata_d   = data_q[head_q];
      end

      case ({push_c, pop_c})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Control state registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= '0;
         wen_q     <= 1'b0;
         rd_addr_q <= '0;
         wdata_q   <= '0;
      end else begin
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
         wen_q     <= wen_d;
         rd_addr_q <= rd_addr_d;
         wdata_q   <= wdata_d;
      end
   end

   // Entry payload storage; validity is tracked solely by head/count
   always_ff @(posedge clk) begin
      if (push_c) begin
         rd_q[tail_q]   <= in_rd_c;
         data_q[tail_q] <= in_data_c;
      end
   end

   // Bypass lookup: output stage is oldest, then head..tail-1; last match wins
   always_comb begin
      rs_addr_c[0] = bus.Rs1_addr;
      rs_addr_c[1] = bus.Rs2_addr;
      for (int p = 0; p < 2; p++) begin
         hit_c[p] = 1'b0;
         fwd_c[p] = '0;
         if (rs_addr_c[p] != '0) begin
            if (wen_q && (rd_addr_q == rs_addr_c[p])) begin
               hit_c[p] = 1'b1;
               fwd_c[p] = wdata_q;
            end
            for (int i = 0; i < int'(DEPTH); i++) begin
               if ((CW'(i) < count_q) &&
                   (rd_q[head_q + PW'(i)] == rs_addr_c[p])) begin
                  hit_c[p] = 1'b1;
                  fwd_c[p] = data_q[head_q + PW'(i)];
               end
            end
         end
      end
   end

   // Output drive
   assign bus.alu_ready  = alu_ready_c;
   assign bus.mem_ready  = mem_ready_c;
   assign bus.Wen        = wen_q;
   assign bus.Rd_addr    = rd_addr_q;
   assign bus.write_data = wdata_q;
   assign bus.rs1_hit    = hit_c[0];
   assign bus.rs1_fwd    = fwd_c[0];
   assign bus.rs2_hit    = hit_c[1];
   assign bus.rs2_fwd    = fwd_c[1];
   assign bus.count      = count_q;
   assign bus.empty      = (count_q == '0);

endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue: per-cycle vector table plus a latency/sign
// sequence on the write port.
module tb_wb_queue;
   localparam int unsigned XLEN  = 64;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned AW    = 5;

   typedef struct {
      logic        rst;
      logic        av;
      logic [4:0]  ard;
      logic [63:0] adat;
      logic        mv;
      logic [4:0]  mrd;
      logic [63:0] mdat;
      logic        g;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic        e_ar;
      logic        e_mr;
      logic        e_wen;
      logic [4:0]  e_ra;
      logic [63:0] e_wd;
      logic        e_h1;
      logic [63:0] e_f1;
      logic        e_h2;
      logic [63:0] e_f2;
      logic [2:0]  e_cnt;
   } vec_t;

   logic clk;
   logic rst;
   int   tests;
   int   failed;
   vec_t vecs [$];

   wb_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH), .AW(AW)) bus ();

   wb_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .AW(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(
      input int rst_v, input int av, input int ard, input int adat,
      input int mv, input int mrd, input int mdat, input int g,
      input int rs1, input int rs2,
      input int ear, input int emr, input int ewen, input int era,
      input int ewd, input int eh1, input int ef1, input int eh2,
      input int ef2, input int ecnt);
      vec_t v;
      v.rst   = 1'(rst_v);
      v.av    = 1'(av);
      v.ard   = 5'(ard);
      v.adat  = 64'(adat);
      v.mv    = 1'(mv);
      v.mrd   = 5'(mrd);
      v.mdat  = 64'(mdat);
      v.g     = 1'(g);
      v.rs1   = 5'(rs1);
      v.rs2   = 5'(rs2);
      v.e_ar  = 1'(ear);
      v.e_mr  = 1'(emr);
      v.e_wen = 1'(ewen);
      v.e_ra  = 5'(era);
      v.e_wd  = 64'(ewd);
      v.e_h1  = 1'(eh1);
      v.e_f1  = 64'(ef1);
      v.e_h2  = 1'(eh2);
      v.e_f2  = 64'(ef2);
      v.e_cnt = 3'(ecnt);
      return v;
   endfunction

   task automatic check(input string name, input int row,
                        input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
      end
   endtask

   task automatic drive_idle();
      bus.alu_valid = 1'b0;
      bus.alu_rd    = '0;
      bus.alu_data  = '0;
      bus.mem_valid = 1'b0;
      bus.mem_rd    = '0;
      bus.mem_data  = '0;
      bus.rf_grant  = 1'b0;
      bus.Rs1_addr  = '0;
      bus.Rs2_addr  = '0;
   endtask

   initial begin
      int edges;
      tests  = 0;
      failed = 0;

      // Columns: rst av ard adat mv mrd mdat g rs1 rs2 | ar mr wen ra wd h1 f1 h2 f2 cnt
      // reset holds readies low
      vecs.push_back(mk(1,1,9,1,      1,9,2,     1, 9,0,  0,0,0,0,0,      0,0,0,0,0));
      // basic write x5=1234
      vecs.push_back(mk(0,1,5,'h1234, 0,0,0,     1, 5,0,  1,1,0,0,0,      0,0,0,0,0));
      vecs.push_back(mk(0,0,0,0,      0,0,0,     1, 5,0,  1,1,0,0,0,      1,'h1234,0,0,1));
      vecs.push_back(mk(0,0,0,0,      0,0,0,     1, 5,0,  1,1,1,5,'h1234, 1,'h1234,0,0,0));
      vecs.push_back(mk(0,0,0,0,      0,0,0,     1, 5,0,  1,1,0,5,'h1234, 0,0,0,0,0));
      // arbitration: mem x3=9 wins, alu x4=7 next cycle
      vecs.push_back(mk(0,1,4,7,      1,3,9,     1, 3,4,  0,1,0,5,'h1234, 0,0,0,0,0));
      vecs.push_back(mk(0,1,4,7,      0,0,0,     1, 3,4,  1,1,0,5,'h1234, 1,9,0,0,1));
      vecs.push_back(mk(0,0,0,0,      0,0,0,     1, 3,4,  1,1,1,3,9,      1,9,1,7,1));
      vecs.push_back(mk(0,0,0,0,      0,0,0,     1, 3,4,  1,1,1,4,7,      0,0,1,7,0));
      // x0 drop
      vecs.push_back(mk(0,1,0,'hFFF,  0,0,0,     1, 0,4,  1,1,0,4,7,      0,0,0,0,0));
      vecs.push_back(mk(0,0,0,0,      0,0,0,     1, 0,0,  1,1,0,4,7,      0,0,0,0,0));
      vecs.push_back(mk(0,0,0,0,      0,0,0,     1, 0,0,  1,1,0,4,7,      0,0,0,0,0));
      // backpressure, full, drain with pointer wrap
      vecs.push_back(mk(0,1,1,'h10,   0,0,0,     0, 1,4,  1,1,0,4,7,      0,0,0,0,0));
      vecs.push_back(mk(0,1,2,'h20,   0,0,0,     0, 1,4,  1,1,0,4,7,      1,'h10,0,0,1));
      vecs.push_back(mk(0,1,3,'h30,   0,0,0,     0, 1,4,  1,1,0,4,7,      1,'h10,0,0,2));
      vecs.push_back(mk(0,1,4,'h40,   0,0,0,     0, 1,4,  1,1,0,4,7,      1,'h10,0,0,3));
      vecs.push_back(mk(0,1,5,'h50,   0,0,0,     0, 1,4,  0,0,0,4,7,      1,'h10,1,'h40,4));
      vecs.push_back(mk(0,1,5,'h50,   0,0,0,     1, 1,4,  0,0,0,4,7,      1,'h10,1,'h40,4));
      vecs.push_back(mk(0,1,5,'h50,   0,0,0,     1, 1,4,  1,1,1,1,'h10,   1,'h10,1,'h40,3));
      vecs.push_back(mk(0,1,6,'h60,   0,0,0,     1, 1,4,  1,1,1,2,'h20,   0,0,1,'h40,3));
      vecs.push_back(mk(0,0,0,0,      0,0,0,     1, 1,4,  1,1,1,3,'h30,   0,0,1,'h40,3));
      vecs.push_back(mk(0,0,0,0,      0,0,0,     1, 1,4,  1,1,1,4,'h40,   0,0,1,'h40,2));
      vecs.push_back(mk(0,0,0,0,      0,0,0,     1, 1,4,  1,1,1,5,'h50,   0,0,0,0,1));
      vecs.push_back(mk(0,0,0,0,      0,0,0,     1, 1,4,  1,1,1,6,'h60,   0,0,0,0,0));
      vecs.push_back(mk(0,0,0,0,      0,0,0,     1, 1,4,  1,1,0,6,'h60,   0,0,0,0,0));
      // forwarding: x7=8 then x7=4, youngest wins
      vecs.push_back(mk(0,1,7,8,      0,0,0,     0, 7,7,  1,1,0,6,'h60,   0,0,0,0,0));
      vecs.push_back(mk(0,0,0,0,      1,7,4,     0, 7,7,  0,1,0,6,'h60,   1,8,1,8,1));
      vecs.push_back(mk(0,0,0,0,      0,0,0,     0, 7,7,  1,1,0,6,'h60,   1,4,1,4,2));
      vecs.push_back(mk(0,0,0,0,      0,0,0,     1, 7,7,  1,1,0,6,'h60,   1,4,1,4,2));
      vecs.push_back(mk(0,0,0,0,      0,0,0,     1, 7,7,  1,1,1,7,8,      1,4,1,4,1));
      vecs.push_back(mk(0,0,0,0,      0,0,0,     1, 7,7,  1,1,1,7,4,      1,4,1,4,0));
      vecs.push_back(mk(0,0,0,0,      0,0,0,     1, 7,7,  1,1,0,7,4,      0,0,0,0,0));
      // reset mid-operation with three queued entries
      vecs.push_back(mk(0,0,0,0,      1,8,'h80,  0, 8,10, 0,1,0,7,4,      0,0,0,0,0));
      vecs.push_back(mk(0,0,0,0,      1,9,'h90,  0, 8,10, 0,1,0,7,4,      1,'h80,0,0,1));
      vecs.push_back(mk(0,0,0,0,      1,10,'hA0, 0, 8,10, 0,1,0,7,4,      1,'h80,0,0,2));
      vecs.push_back(mk(1,0,0,0,      0,0,0,     1, 8,10, 0,0,0,7,4,      1,'h80,1,'hA0,3));
      vecs.push_back(mk(0,0,0,0,      0,0,0,     1, 8,10, 1,1,0,0,0,      0,0,0,0,0));
      vecs.push_back(mk(0,0,0,0,      0,0,0,     1, 8,10, 1,1,0,0,0,      0,0,0,0,0));
      vecs.push_back(mk(0,0,0,0,      0,0,0,     1, 8,10, 1,1,0,0,0,      0,0,0,0,0));

      // Initial reset
      rst = 1'b1;
      drive_idle();
      repeat (2) @(posedge clk);

      // Vector table: inputs driven after negedge, outputs sampled 1 later
      foreach (vecs[r]) begin
         @(negedge clk);
         rst           = vecs[r].rst;
         bus.alu_valid = vecs[r].av;
         bus.alu_rd    = vecs[r].ard;
         bus.alu_data  = vecs[r].adat;
         bus.mem_valid = vecs[r].mv;
         bus.mem_rd    = vecs[r].mrd;
         bus.mem_data  = vecs[r].mdat;
         bus.rf_grant  = vecs[r].g;
         bus.Rs1_addr  = vecs[r].rs1;
         bus.Rs2_addr  = vecs[r].rs2;
         #1;
         check("alu_ready",  r, 64'(bus.alu_ready),  64'(vecs[r].e_ar));
         check("mem_ready",  r, 64'(bus.mem_ready),  64'(vecs[r].e_mr));
         check("Wen",        r, 64'(bus.Wen),        64'(vecs[r].e_wen));
         check("Rd_addr",    r, 64'(bus.Rd_addr),    64'(vecs[r].e_ra));
         check("write_data", r, bus.write_data,      vecs[r].e_wd);
         check("rs1_hit",    r, 64'(bus.rs1_hit),    64'(vecs[r].e_h1));
         check("rs1_fwd",    r, bus.rs1_fwd,         vecs[r].e_f1);
         check("rs2_hit",    r, 64'(bus.rs2_hit),    64'(vecs[r].e_h2));
         check("rs2_fwd",    r, bus.rs2_fwd,         vecs[r].e_f2);
         check("count",      r, 64'(bus.count),      64'(vecs[r].e_cnt));
         check("empty",      r, 64'(bus.empty),      64'(vecs[r].e_cnt == 3'd0));
      end

      // Latency and signed pass-through of a negative value on x31
      @(negedge clk);
      rst           = 1'b0;
      drive_idle();
      bus.alu_valid = 1'b1;
      bus.alu_rd    = 5'd31;
      bus.alu_data  = 64'h8000_0000_0000_0001;
      bus.rf_grant  = 1'b1;
      bus.Rs2_addr  = 5'd31;
      #1;
      check("lat_ready", 100, 64'(bus.alu_ready), 64'd1);
      @(posedge clk);
      #1;
      bus.alu_valid = 1'b0;
      edges = 1;
      check("lat_fwd", 101, bus.rs2_fwd, 64'h8000_0000_0000_0001);
      while (!bus.Wen && edges < 6) begin
         @(posedge clk);
         #1;
         edges++;
      end
      check("lat_edges",  102, 64'(edges),          64'd2);
      check("lat_addr",   103, 64'(bus.Rd_addr),    64'd31);
      check("lat_data",   104, bus.write_data,      64'h8000_0000_0000_0001);
      check("lat_signed", 105, 64'($signed(bus.write_data) < 0), 64'd1);
      @(posedge clk);
      #1;
      check("lat_single", 106, 64'(bus.Wen),        64'd0);
      check("lat_empty",  107, 64'(bus.empty),      64'd1);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule

// File: doc/wb_queue.md
Name: wb_queue

Overview:
Writeback queue that drives the write side of the 64-bit, 32-entry register file.
- Accepts results from the ALU path and the load/memory path over valid/ready handshakes.
- Buffers them in order and issues exactly one register-file write per granted cycle on Wen/Rd_addr/write_data.
- Exposes a combinational pending-write lookup and youngest-value forward for both source operands (Rs1/Rs2), so decode can bypass writes not yet committed.

Parameters:
XLEN, 64, data width of register-file entries
DEPTH, 4, queue entries (power of 2, >=2)
AW, 5, register address width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
alu_valid  in  1  ALU result available
alu_ready  out  1  ALU result accepted this cycle
alu_rd  in  AW  ALU destination register
alu_data  in  XLEN  ALU result
mem_valid  in  1  load result available
mem_ready  out  1  load result accepted this cycle
mem_rd  in  AW  load destination register
mem_data  in  XLEN  load result
rf_grant  in  1  register-file write port free this cycle
Wen  out  1  register-file write enable (registered)
Rd_addr  out  AW  register-file write address (registered)
write_data  out  XLEN  register-file write data (registered, signed)
Rs1_addr  in  AW  source-1 lookup address
Rs2_addr  in  AW  source-2 lookup address
rs1_hit  out  1  pending write to Rs1_addr exists
rs1_fwd  out  XLEN  youngest pending value for Rs1_addr
rs2_hit  out  1  pending write to Rs2_addr exists
rs2_fwd  out  XLEN  youngest pending value for Rs2_addr
count  out  clog2(DEPTH)+1  valid queue entries
empty  out  1  count==0

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high (clk, rst).
- Reset values: count=0, pointers=0, all entries invalid, Wen=0, Rd_addr=0, write_data=0.
  - alu_ready=mem_ready=0 while rst=1.
  - Reset mid-operation discards all queued entries; no Wen follows.
- Enqueue: at most one per cycle.
  - mem_ready = !rst && count<DEPTH.
  - alu_ready = !rst && count<DEPTH && !mem_valid. The load path has fixed priority.
  - Ready never depends on same-cycle pop, so there is no combinational path from rf_grant.
- x0 rule: an accepted result with rd==0 completes the handshake but is not stored. count is unchanged, and it never hits.
- Drain: when rf_grant=1 and count>0 at the edge, the head is popped into the output stage.
  - Wen=1 with Rd_addr/write_data equal to the head for exactly the next cycle.
  - Otherwise Wen=0, and Rd_addr/write_data hold their last values.
- Latency: accept at edge N, with an empty queue and rf_grant=1 -> Wen=1 during cycle N+1..N+2 (pop at edge N+1). Minimum is 2 edges.
- Simultaneous push and pop: count unchanged, both pointers advance. Pointers wrap modulo DEPTH.
- Ordering: writes leave in acceptance order. Two writes to the same rd both issue, oldest first.
- Full: count==DEPTH -> both readies 0; pop still allowed.
- Empty: no Wen regardless of rf_grant.
- Lookup (combinational): pending set = valid queue entries plus the output stage when Wen=1.
  - rsX_hit=1 iff Rs_addr!=0 and it matches any pending rd.
  - rsX_fwd = data of the youngest match, in priority order: tail-1 ... head, then output stage.
  - rsX_fwd=0 when there is no hit.
- write_data is treated as signed. No arithmetic is applied to data; width is passed through unchanged.

Test Plan:
- Basic write: rf_grant=1, one cycle of alu_valid with rd=5, data=64'h1234 -> alu_ready=1. Wen=1, Rd_addr=5, write_data=64'h1234 exactly 2 edges later, for one cycle.
- Arbitration: both valid in the same cycle, mem rd=3 data=9 and alu rd=4 data=7 -> mem accepted, alu_ready=0. alu is accepted the next cycle. Wen sequence is x3=9 then x4=7 on consecutive cycles.
- x0 drop: alu rd=0 data=64'hFFF -> alu_ready=1, count stays 0, no Wen, rs1_hit=0 for Rs1_addr=0.
- Backpressure and wrap: rf_grant=0, push 6 entries into rd=1..6 -> only 4 accepted, count=4, both readies 0. Raise rf_grant -> Wen for x1..x4 on 4 consecutive cycles, then remaining pushes proceed. Pointers wrap correctly.
- Forwarding: rf_grant=0, push x7=8 then x7=4, Rs1_addr=7 -> rs1_hit=1, rs1_fwd=4. After both drain and the output stage clears, rs1_hit=0.
- Reset mid-operation: count=3, assert rst one cycle -> next cycle count=0, Wen=0, Rd_addr=0, write_data=0. No queued write is ever issued.
